decode_stage: RTL
=================

Name: decode_stage

Overview:
- Parametrised successor to the LC-3b decode stage: register file, immediate/offset generation and control lookup, plus a registered ID/EX pipeline boundary.
- Adds what the previous decode lacked:
  - valid/ready handshake with backpressure;
  - synchronous flush;
  - write-back-to-read bypass;
  - load-use hazard detection with bubble insertion;
  - saturating stall counter.
- Sits between the fetch stage and the execute stage.

Parameters:
- WIDTH, 16, datapath and register width in bits.
- NUM_REGS, 8, register count; addresses are $clog2(NUM_REGS) bits (RA_W).
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- if_valid  input  1  fetch presents an instruction.
- if_instruction  input  16  instruction word.
- if_pc  input  WIDTH  PC+2 of the instruction.
- id_ready  output  1  decode accepts if_* this cycle.
- ex_ready  input  1  execute accepts ID/EX contents this cycle.
- flush  input  1  kill the instruction in decode and in ID/EX.
- wb_load  input  1  register file write enable.
- wb_dest  input  RA_W  final write address (R7 selection resolved upstream).
- wb_data  input  WIDTH  write data.
- ex_valid  output  1  ID/EX holds a live instruction.
- ex_ctrl  output  lc3b_control_word  registered control word from the existing control unit.
- ex_pc, ex_sr1, ex_sr2, ex_imm, ex_adj, ex_trapvect  output  WIDTH  registered operands.
- ex_dest  output  RA_W  registered instr[11:9].
- stall_count  output  CNT_W  number of hazard bubbles inserted.

Behaviour:
- Reset (rst_n=0, asynchronous): all registers 0, ex_valid 0, all ex_* outputs 0, stall_count 0. Reset mid-stall discards the held instruction.
- Register file:
  - NUM_REGS x WIDTH; written on the clk edge when wb_load=1.
  - Reads are combinational, with bypass: if wb_load and wb_dest equals the read address, the read returns wb_data in the same cycle.
- Source selection:
  - src1 = instr[8:6].
  - src2 = instr[11:9] when ctrl.storemux_sel=1, else instr[2:0].
- Operand generation, all extended to WIDTH:
  - sext5(instr[4:0]), sext6(instr[5:0]), zext4(instr[3:0]).
  - adj6/adj9/adj11 = sign-extend then shift left by 1.
  - ex_trapvect = zext(instr[7:0]) << 1.
  - ex_imm is chosen by ctrl.alumux_sel: 0 gives 0, 1 adj6, 2 sext5, 3 sext6, 4 zext4, 5-7 give 0.
  - ex_adj = adj11 if ctrl.adjmux_sel=1, else adj9.
- Source use, decoded from opcode:
  - ADD/AND: src1; src2 only if instr[5]=0.
  - NOT, SHF, LDR, LDB, LDI, JMP: src1.
  - JSR: src1 only if instr[11]=0.
  - STR, STB, STI: src1 and src2.
  - All others: no sources.
- Hazard:
  - hazard = if_valid & ex_valid & ex_is_load & (ex_dest matches a used source).
  - ex_is_load is a registered flag, set when the ID/EX instruction is LDR, LDB or LDI.
- Handshake: id_ready = flush | (~hazard & (ex_ready | ~ex_valid)).
- Per-edge update, in priority order:
  1. flush=1: ex_valid<=0; the if_* transfer is consumed and discarded.
  2. ex_ready=0 and ex_valid=1: hold all ID/EX registers.
  3. hazard: ex_valid<=0 (bubble); if_* is held by fetch because id_ready=0; stall_count increments.
  4. Otherwise: capture all ID/EX fields; ex_valid<=if_valid.
- Latency: 1 cycle from handshake to ex_valid.
- Operand freshness: sr1/sr2 are sampled through the bypass on the capture edge, so a write-back in the same cycle is observed.
- stall_count saturates at all-ones and never wraps.
- Simultaneous flush and hazard: flush wins; no count increment.

Test Plan:
- Reset then ADD R1,R2,R3 (0x1283) with R2=5, R3=7 preloaded via wb -> next cycle ex_valid=1, ex_sr1=5, ex_sr2=7, ex_imm=0, ex_dest=1.
- Bypass: wb_load=1, wb_dest=2, wb_data=0x1234 in the same cycle that ADD R1,R2,#-1 (0x12BF) is accepted -> ex_sr1=0x1234, ex_imm=0xFFFF.
- Load-use: LDR R4,R0,#2 (0x6802) followed by ADD R5,R4,R4, ex_ready=1 -> one cycle with id_ready=0 and ex_valid=0; ADD issues the following cycle; stall_count=1.
- No false stall: LDR R4 followed by ADD R5,R6,#4 (imm form; R4 appears only in instr[2:0]) -> no bubble; stall_count stays 0.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 -> ID/EX outputs stable, id_ready=0; with flush asserted in cycle 2 -> ex_valid=0 next edge.
- Saturation/reset: CNT_W=2, force 5 hazards -> stall_count=3; pulse rst_n low mid-stall -> all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/lc3b_pkg.sv
// Shared LC-3b encodings and the decode control word carried into execute.
package lc3b_pkg;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_STB  = 4'h3;
    localparam logic [3:0] OP_JSR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_RTI  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_SHF  = 4'hD;
    localparam logic [3:0] OP_LEA  = 4'hE;
    localparam logic [3:0] OP_TRAP = 4'hF;

    // ALU B-operand immediate selection
    localparam logic [2:0] ALUMUX_ZERO  = 3'd0;
    localparam logic [2:0] ALUMUX_ADJ6  = 3'd1;
    localparam logic [2:0] ALUMUX_SEXT5 = 3'd2;
    localparam logic [2:0] ALUMUX_SEXT6 = 3'd3;
    localparam logic [2:0] ALUMUX_ZEXT4 = 3'd4;

    typedef struct packed {
        logic [3:0] opcode;
        logic       storemux_sel;   // src2 from instr[11:9] (store data)
        logic [2:0] alumux_sel;
        logic       adjmux_sel;     // 1: adj11 (JSR), 0: adj9
        logic       load_regfile;
        logic       load_cc;
        logic       mem_read;
        logic       mem_write;
        logic       mem_byte;
        logic       mem_indirect;
        logic       pc_redirect;
    } lc3b_control_word;

endpackage

// File: rtl/decode_stage.sv
// LC-3b decode stage: register file with write-back bypass, immediate
// generation, control lookup, load-use hazard bubbles and ID/EX register.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   if_valid/if_instruction/if_pc   instruction from fetch; id_ready accepts it
//   ex_ready, flush             execute backpressure, pipeline kill
//   wb_load/wb_dest/wb_data     register file write port
//   ex_*                        registered ID/EX contents
//   stall_count                 saturating count of hazard bubbles
module decode_stage
    import lc3b_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned RA_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [15:0]      if_instruction,
    input  logic [WIDTH-1:0] if_pc,
    output logic             id_ready,
    input  logic             ex_ready,
    input  logic             flush,
    input  logic             wb_load,
    input  logic [RA_W-1:0]  wb_dest,
    input  logic [WIDTH-1:0] wb_data,
    output logic             ex_valid,
    output lc3b_control_word ex_ctrl,
    output logic [WIDTH-1:0] ex_pc,
    output logic [WIDTH-1:0] ex_sr1,
    output logic [WIDTH-1:0] ex_sr2,
    output logic [WIDTH-1:0] ex_imm,
    output logic [WIDTH-1:0] ex_adj,
    output logic [WIDTH-1:0] ex_trapvect,
    output logic [RA_W-1:0]  ex_dest,
    output logic [CNT_W-1:0] stall_count
);

    logic [WIDTH-1:0] rf [NUM_REGS];
    logic [3:0]       opcode;
    lc3b_control_word ctrl_c;
    logic [RA_W-1:0]  src1_addr, src2_addr, dest_addr;
    logic [WIDTH-1:0] sr1_c, sr2_c, imm_c, adj_c, trap_c;
    logic [WIDTH-1:0] sext5, sext6, zext4, adj6, adj9, adj11;
    logic             use1_c, use2_c, is_load_c, hazard;
    logic             ex_is_load;

    assign opcode = if_instruction[15:12];

    // Control lookup
    always_comb begin
        ctrl_c            = '0;
        ctrl_c.opcode     = opcode;
        ctrl_c.alumux_sel = ALUMUX_ZERO;
        case (opcode)
            OP_ADD, OP_AND: begin
                ctrl_c.load_regfile = 1'b1;
                ctrl_c.load_cc      = 1'b1;
                ctrl_c.alumux_sel   = if_instruction[5] ? ALUMUX_SEXT5 : ALUMUX_ZERO;
            end
            OP_NOT: begin
                ctrl_c.load_regfile = 1'b1;
                ctrl_c.load_cc      = 1'b1;
            end
            OP_SHF: begin
                ctrl_c.load_regfile = 1'b1;
                ctrl_c.load_cc      = 1'b1;
                ctrl_c.alumux_sel   = ALUMUX_ZEXT4;
            end
            OP_LDR, OP_LDB, OP_LDI: begin
                ctrl_c.load_regfile = 1'b1;
                ctrl_c.load_cc      = 1'b1;
                ctrl_c.mem_read     = 1'b1;
                ctrl_c.mem_byte     = (opcode == OP_LDB);
                ctrl_c.mem_indirect = (opcode == OP_LDI);
                ctrl_c.alumux_sel   = (opcode == OP_LDB) ? ALUMUX_SEXT6 : ALUMUX_ADJ6;
            end
            OP_STR, OP_STB, OP_STI: begin
                ctrl_c.storemux_sel = 1'b1;
                ctrl_c.mem_write    = 1'b1;
                ctrl_c.mem_byte     = (opcode == OP_STB);
                ctrl_c.mem_indirect = (opcode == OP_STI);
                ctrl_c.alumux_sel   = (opcode == OP_STB) ? ALUMUX_SEXT6 : ALUMUX_ADJ6;
            end
            OP_JSR: begin
                ctrl_c.load_regfile = 1'b1;
                ctrl_c.pc_redirect  = 1'b1;
                ctrl_c.adjmux_sel   = 1'b1;
            end
            OP_BR, OP_JMP, OP_RTI: ctrl_c.pc_redirect = 1'b1;
            OP_TRAP: begin
                ctrl_c.load_regfile = 1'b1;
                ctrl_c.pc_redirect  = 1'b1;
            end
            OP_LEA: begin
                ctrl_c.load_regfile = 1'b1;
                ctrl_c.load_cc      = 1'b1;
            end
            default: ;
        endcase
    end

    // Which source registers the fetched instruction actually reads
    always_comb begin
        use1_c = 1'b0;
        use2_c = 1'b0;
        case (opcode)
            OP_ADD, OP_AND: begin
                use1_c = 1'b1;
                use2_c = ~if_instruction[5];
            end
            OP_NOT, OP_SHF, OP_LDR, OP_LDB, OP_LDI, OP_JMP: use1_c = 1'b1;
            OP_JSR: use1_c = ~if_instruction[11];
            OP_STR, OP_STB, OP_STI: begin
                use1_c = 1'b1;
                use2_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign is_load_c = ctrl_c.mem_read;
    assign src1_addr = RA_W'(if_instruction[8:6]);
    assign src2_addr = ctrl_c.storemux_sel ? RA_W'(if_instruction[11:9])
                                           : RA_W'(if_instruction[2:0]);
    assign dest_addr = RA_W'(if_instruction[11:9]);

    // Reads see a same-cycle write-back
    assign sr1_c = (wb_load && (wb_dest == src1_addr)) ? wb_data : rf[src1_addr];
    assign sr2_c = (wb_load && (wb_dest == src2_addr)) ? wb_data : rf[src2_addr];

    // Immediate and offset generation
    assign sext5  = {{(WIDTH-5){if_instruction[4]}}, if_instruction[4:0]};
    assign sext6  = {{(WIDTH-6){if_instruction[5]}}, if_instruction[5:0]};
    assign zext4  = WIDTH'(if_instruction[3:0]);
    assign adj6   = {{(WIDTH-7){if_instruction[5]}}, if_instruction[5:0], 1'b0};
    assign adj9   = {{(WIDTH-10){if_instruction[8]}}, if_instruction[8:0], 1'b0};
    assign adj11  = {{(WIDTH-12){if_instruction[10]}}, if_instruction[10:0], 1'b0};
    assign trap_c = WIDTH'({if_instruction[7:0], 1'b0});
    assign adj_c  = ctrl_c.adjmux_sel ? adj11 : adj9;

    always_comb begin
        imm_c = '0;
        case (ctrl_c.alumux_sel)
            ALUMUX_ADJ6:  imm_c = adj6;
            ALUMUX_SEXT5: imm_c = sext5;
            ALUMUX_SEXT6: imm_c = sext6;
            ALUMUX_ZEXT4: imm_c = zext4;
            default:      imm_c = '0;
        endcase
    end

    assign hazard = if_valid & ex_valid & ex_is_load &
                    ((use1_c & (ex_dest == src1_addr)) | (use2_c & (ex_dest == src2_addr)));

    assign id_ready = flush | (~hazard & (ex_ready | ~ex_valid));

    // Register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (wb_load) begin
            rf[wb_dest] <= wb_data;
        end
    end

    // ID/EX boundary: flush > hold > bubble > capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_ctrl     <= '0;
            ex_pc       <= '0;
            ex_sr1      <= '0;
            ex_sr2      <= '0;
            ex_imm      <= '0;
            ex_adj      <= '0;
            ex_trapvect <= '0;
            ex_dest     <= '0;
            stall_count <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (ex_valid && !ex_ready) begin
            ex_valid <= ex_valid;
        end else if (hazard) begin
            ex_valid <= 1'b0;
            if (stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + CNT_W'(1);
        end else begin
            ex_valid    <= if_valid;
            ex_is_load  <= is_load_c;
            ex_ctrl     <= ctrl_c;
            ex_pc       <= if_pc;
            ex_sr1      <= sr1_c;
            ex_sr2      <= sr2_c;
            ex_imm      <= imm_c;
            ex_adj      <= adj_c;
            ex_trapvect <= trap_c;
            ex_dest     <= dest_addr;
        end
    end

endmodule
